// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_LS, RESP_IF, RESP_LS} state_t;
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;
endpackage

// File: rtl/mem_port_arb_if.sv
// mem_port_arb_if: fetch, load/store and memory handshake bundle around the arbiter.
interface mem_port_arb_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          if_req, if_ack;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_ack;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
        output if_ack, if_rdata, ls_ack, ls_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
        input  if_ack, if_rdata, ls_ack, ls_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arb_rr_arb2.sv
// rr_arb2: two-way round-robin pick favouring the requester not served last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic req_if,
    input  logic req_ls,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);
    always_comb begin
        grant_valid = req_if || req_ls;
        grant = (req_if && (!req_ls || last_grant == GRANT_LS)) ? GRANT_IF : GRANT_LS;
    end
endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one variable-latency memory between fetch and load/store
// with round-robin arbitration, a sticky timeout error and registered read data.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_port_arb_if.slave bus,
    output logic          busy,
    output logic          err
);
    state_t        state;
    logic          last_grant, grant, grant_valid, done;
    logic [7:0]    cnt;
    logic [DW-1:0] rdata_next;

    rr_arb2 u_arb (
        .req_if(bus.if_req),
        .req_ls(bus.ls_req),
        .last_grant(last_grant),
        .grant_valid(grant_valid),
        .grant(grant)
    );

    assign busy = state != IDLE;
    assign done = bus.mem_ack || cnt == 8'(TIMEOUT - 1);
    assign rdata_next = bus.mem_ack ? bus.mem_rdata : DW'(TIMEOUT_RDATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= GRANT_LS;
            cnt           <= '0;
            err           <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_ack    <= 1'b0;
            bus.ls_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.ls_rdata  <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.ls_ack <= 1'b0;
            case (state)
                IDLE: if (grant_valid) begin
                    state         <= (grant == GRANT_IF) ? BUSY_IF : BUSY_LS;
                    last_grant    <= grant;
                    cnt           <= '0;
                    bus.mem_req   <= 1'b1;
                    bus.mem_addr  <= AW'((grant == GRANT_IF) ? bus.if_addr : bus.ls_addr);
                    bus.mem_we    <= (grant == GRANT_LS) && bus.ls_we;
                    bus.mem_wdata <= bus.ls_wdata;
                end
                BUSY_IF, BUSY_LS: if (done) begin
                    // a timeout completes like an ack but returns zero data and latches err
                    state       <= (state == BUSY_IF) ? RESP_IF : RESP_LS;
                    bus.mem_req <= 1'b0;
                    bus.if_ack  <= (state == BUSY_IF);
                    bus.ls_ack  <= (state == BUSY_LS);
                    err         <= err || !bus.mem_ack;
                    if (state == BUSY_IF) bus.if_rdata <= rdata_next;
                    else if (!bus.mem_we) bus.ls_rdata <= rdata_next;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: scoreboard bench with a behavioural memory and a reference memory image.
module tb_mem_port_arb;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err;

    mem_port_arb_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] dev_mem [int];
    logic [31:0] ref_mem [int];
    logic [31:0] if_exp [$];
    logic [31:0] ls_exp [$];
    int ack_log [$];
    int req_cycles = 0, we_cycles = 0, if_acks = 0, ls_acks = 0;
    int mem_wait = 0;
    int stray_cnt = 0;
    bit rand_mode = 1'b0;
    logic [31:0] ls_last = '0;

    function automatic logic [31:0] init_word(int a);
        return 32'(32'h9E3779B9 * (a + 1)) ^ 32'h0F0F_0000;
    endfunction

    function automatic logic [31:0] dev_rd(int a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // memory device: acks after a chosen number of wait cycles, -1 never acks
    initial begin
        int wcnt = 0, cur_wait = 0, stray_done = 0;
        logic prev = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            bus.mem_rdata = $urandom;
            if (stray_done != stray_cnt) begin
                stray_done++;
                bus.mem_ack = 1'b1;
            end else if (bus.mem_req) begin
                if (!prev) begin
                    cur_wait = rand_mode ? int'($urandom_range(0, 3)) : mem_wait;
                    wcnt = 0;
                end
                if (cur_wait >= 0 && wcnt >= cur_wait) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) dev_mem[int'(bus.mem_addr)] = bus.mem_wdata;
                    else bus.mem_rdata = dev_rd(int'(bus.mem_addr));
                end else begin
                    wcnt++;
                end
            end
            prev = bus.mem_req;
        end
    end

    // monitor: pops expected read data on every ack, watches bus stability
    initial begin
        logic pi = 1'b0, pl = 1'b0, pr = 1'b0;
        logic [42:0] held = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) req_cycles++;
            if (bus.mem_req && bus.mem_we) we_cycles++;
            if (bus.mem_req && pr) check("mem_bus_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, held);
            held = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
            pr = bus.mem_req;
            if (bus.if_ack) begin
                if_acks++;
                ack_log.push_back(0);
                check("if_ack_one_cycle", 64'(pi), 0);
                check("if_ack_expected", 64'(if_exp.size() != 0), 1);
                if (if_exp.size() != 0) check("if_rdata", bus.if_rdata, if_exp.pop_front());
            end
            if (bus.ls_ack) begin
                ls_acks++;
                ack_log.push_back(1);
                check("ls_ack_one_cycle", 64'(pl), 0);
                check("ls_ack_expected", 64'(ls_exp.size() != 0), 1);
                if (ls_exp.size() != 0) check("ls_rdata", bus.ls_rdata, ls_exp.pop_front());
            end
            pi = bus.if_ack;
            pl = bus.ls_ack;
        end
    end

    task automatic fetch(int a, output int lat);
        if_exp.push_back(ref_rd(a));
        @(negedge clk);
        bus.if_req = 1'b1;
        bus.if_addr = AW'(a);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.if_ack && lat < 200);
        if (!bus.if_ack) check("if_ack_wait_expired", 64'(lat), 0);
        bus.if_req = 1'b0;
    endtask

    task automatic ls_op(int a, bit we, logic [31:0] d, logic [31:0] exp, output int lat);
        ls_exp.push_back(exp);
        @(negedge clk);
        bus.ls_req = 1'b1;
        bus.ls_we = we;
        bus.ls_addr = AW'(a);
        bus.ls_wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.ls_ack && lat < 200);
        if (!bus.ls_ack) check("ls_ack_wait_expired", 64'(lat), 0);
        bus.ls_req = 1'b0;
    endtask

    task automatic do_load(int a, output int lat);
        ls_last = ref_rd(a);
        ls_op(a, 1'b0, $urandom, ls_last, lat);
    endtask

    task automatic do_store(int a, logic [31:0] d, output int lat);
        ref_mem[a] = d;
        ls_op(a, 1'b1, d, ls_last, lat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r0, w0, i0, l0, n0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(bus.mem_req), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_err", 64'(err), 0);
        check("rst_acks", {bus.if_ack, bus.ls_ack}, 0);
        check("rst_rdata", {bus.if_rdata, bus.ls_rdata}, 0);
        check("rst_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        rst = 1'b0;

        // zero-wait fetch
        dev_mem[4] = 32'h8C010000;
        ref_mem[4] = 32'h8C010000;
        r0 = req_cycles; l0 = ls_acks;
        fetch(4, lat);
        check("t1_latency", 64'(lat), 2);
        check("t1_req_cycles", 64'(req_cycles - r0), 1);
        check("t1_no_ls_ack", 64'(ls_acks - l0), 0);
        @(negedge clk);
        check("t1_if_rdata_held", bus.if_rdata, 32'h8C010000);

        // store with three wait cycles, then read it back
        mem_wait = 3;
        r0 = req_cycles; w0 = we_cycles;
        do_store(16, 32'h12345678, lat);
        check("t2_latency", 64'(lat), 5);
        check("t2_req_cycles", 64'(req_cycles - r0), 4);
        check("t2_we_cycles", 64'(we_cycles - w0), 4);
        check("t2_mem_written", dev_rd(16), 32'h12345678);
        mem_wait = 0;
        do_load(16, lat);
        check("t2_load_latency", 64'(lat), 2);

        // contention: both held, alternate grants
        n0 = ack_log.size();
        fork
            begin int la; fetch(20, la); fetch(24, la); end
            begin int lb; do_load(600, lb); do_load(604, lb); end
        join
        check("t3_ack_count", 64'(ack_log.size() - n0), 4);
        if (ack_log.size() - n0 == 4) begin
            check("t3_order0", 64'(ack_log[n0]), 0);
            check("t3_order1", 64'(ack_log[n0+1]), 1);
            check("t3_order2", 64'(ack_log[n0+2]), 0);
            check("t3_order3", 64'(ack_log[n0+3]), 1);
        end

        // load timeout
        mem_wait = -1;
        r0 = req_cycles;
        ls_last = '0;
        ls_op(640, 1'b0, '0, '0, lat);
        check("t4_latency", 64'(lat), TO + 1);
        check("t4_req_cycles", 64'(req_cycles - r0), TO);
        check("t4_err_set", 64'(err), 1);
        mem_wait = 0;
        fetch(8, lat);
        check("t4_err_sticky", 64'(err), 1);

        // async reset in the middle of a load
        mem_wait = -1;
        @(negedge clk);
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = AW'(650);
        repeat (3) @(negedge clk);
        check("t5_busy_before", 64'(busy), 1);
        check("t5_req_before", 64'(bus.mem_req), 1);
        #2 rst = 1'b1;
        #1;
        check("t5_req_dropped", 64'(bus.mem_req), 0);
        check("t5_busy_dropped", 64'(busy), 0);
        check("t5_err_cleared", 64'(err), 0);
        check("t5_ls_ack", 64'(bus.ls_ack), 0);
        bus.ls_req = 1'b0;
        ls_last = '0;
        @(negedge clk);
        rst = 1'b0;
        mem_wait = 0;
        n0 = ack_log.size();
        fork
            begin int la; fetch(28, la); end
            begin int lb; do_load(660, lb); end
        join
        check("t5_ack_count", 64'(ack_log.size() - n0), 2);
        if (ack_log.size() - n0 == 2) check("t5_if_first", 64'(ack_log[n0]), 0);

        // stray memory ack while idle
        i0 = if_acks; l0 = ls_acks;
        stray_cnt++;
        repeat (4) @(negedge clk);
        check("t6_no_if_ack", 64'(if_acks - i0), 0);
        check("t6_no_ls_ack", 64'(ls_acks - l0), 0);
        check("t6_idle", 64'(busy), 0);
        do_load(700, lat);
        check("t6_load_latency", 64'(lat), 2);

        // randomized traffic with random memory latency
        rand_mode = 1'b1;
        fork
            for (int i = 0; i < 40; i++) begin
                int la;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                fetch(int'($urandom_range(0, 511)), la);
            end
            for (int j = 0; j < 40; j++) begin
                int lb, a;
                a = 512 + int'($urandom_range(0, 15));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if ($urandom_range(0, 1) == 1) do_store(a, $urandom, lb);
                else do_load(a, lb);
            end
        join
        rand_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("end_if_queue_empty", 64'(if_exp.size()), 0);
        check("end_ls_queue_empty", 64'(ls_exp.size()), 0);
        check("end_err_clear", 64'(err), 0);
        check("end_idle", 64'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbiter and sequencer sharing one single-ported, variable-latency unified memory between the instruction-fetch path (IR load) and the load/store path (DR load / store).
- Replaces the separate instruction and data memories.
- The multicycle control FSM stalls on the per-requester ack pulses.
- Provides round-robin arbitration, a request/ack handshake to the memory, a sticky timeout error, and registered read data.

Parameters:
AW, 10, word-address width (byte address bits [AW+1:2])
DW, 32, data width
TIMEOUT, 15, max cycles waiting for mem_ack before abort (1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch word address
if_ack  out  1  one-cycle completion pulse for fetch
if_rdata  out  DW  fetched word, valid in the if_ack cycle and held after it
ls_req  in  1  load/store request, held until ls_ack
ls_we  in  1  1 = store, 0 = load
ls_addr  in  AW  data word address
ls_wdata  in  DW  store data
ls_ack  out  1  one-cycle completion pulse for load/store
ls_rdata  out  DW  load data, valid in the ls_ack cycle and held after it
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle
busy  out  1  high in any state other than IDLE
err  out  1  sticky timeout flag

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high.
- Reset values (immediate on rst):
  - state = IDLE.
  - mem_req, mem_we, if_ack, ls_ack, busy, err = 0.
  - mem_addr, mem_wdata, if_rdata, ls_rdata = 0.
  - last_grant = LS, so fetch wins the first tie.
- State IDLE:
  - Arbitration uses if_req and ls_req as registered at the clock edge.
  - One request high: grant it.
  - Both high: grant the requester other than last_grant.
  - On grant:
    - latch address, we and wdata into mem_* registers (fetch forces mem_we = 0);
    - set last_grant;
    - clear the timeout counter;
    - go to BUSY_IF or BUSY_LS.
  - Neither high: stay in IDLE.
- State BUSY_x:
  - mem_req = 1; mem_addr, mem_we and mem_wdata are held stable.
  - mem_ack = 1:
    - on a read, latch mem_rdata into the granted requester's rdata register;
    - drop mem_req at the next edge;
    - go to RESP_x.
  - Else, counter increments each cycle. When counter == TIMEOUT-1 with no ack:
    - set err = 1 (sticky until rst);
    - load the granted rdata register with 0 on a read;
    - drop mem_req;
    - go to RESP_x.
- State RESP_x: x_ack = 1 for exactly one cycle, then IDLE.
- Requester contract: drop req in the cycle after seeing ack. Since the arbiter passes through IDLE after RESP, a held req is a new request.
- Latency: req high before edge 0 → mem_req high from cycle 1 → mem_ack in cycle k ≥ 1 → x_ack in cycle k+1. Zero-wait access = 2 cycles from grant to ack.
- Stores: the ls_rdata register keeps its previous value.
- mem_ack outside BUSY_x is ignored, with no state change.
- Requester drops req while in BUSY_x (protocol violation): the transaction still completes and the ack is still pulsed.
- Back-to-back contention: after an IF grant, a pending LS wins next, and vice versa. Neither requester waits more than one foreign transaction.
- rst mid-transaction: mem_req drops asynchronously. The memory must tolerate an abandoned request. No ack is issued.
- Address width: addresses pass through unmodified, with no wrap logic.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, BUSY_IF, BUSY_LS, RESP_IF, RESP_LS};
  - GRANT_IF/GRANT_LS constants;
  - TIMEOUT_RDATA = 32'h0.
- One natural sub-module: rr_arb2, the combinational two-way round-robin pick from (req_if, req_ls, last_grant). The top module holds the FSM, the timeout counter and the data registers.

Test Plan:
- Fetch alone, addr 0x004, memory returns 0x8C010000 with zero wait → mem_req in cycle 1 only; if_ack in cycle 2; if_rdata = 0x8C010000; ls_ack never asserts.
- Store ls_we = 1, addr 0x010, wdata 0x12345678, memory acks after 3 wait cycles → mem_we = 1 and data stable for 4 cycles; ls_ack exactly one cycle after mem_ack; ls_rdata unchanged.
- if_req and ls_req both high from reset, each held until ack → first grant IF, then LS, then IF again. last_grant alternates with no starvation.
- Load with mem_ack never returned, TIMEOUT = 15 → mem_req high 15 cycles then drops; err = 1; ls_ack pulses with ls_rdata = 0; err stays 1 across later good transactions until rst.
- rst asserted mid-BUSY_LS (async, between edges) → mem_req, busy and acks drop immediately. After release, state is IDLE, err = 0, and the first tie goes to IF.
- Stray mem_ack pulse while in IDLE, then a normal load → no spurious ack; the load completes normally with correct data.
